alu_exec: RTL and testbench
===========================

# alu_exec

Registered execute-stage ALU that consumes the 4-bit `opControl` code from the ALU control decoder and the two operands. It produces a result, a zero flag for branch resolution and an illegal-operation flag. Simple operations complete in one cycle. MUL runs as an iterative shift-add over WIDTH cycles. Input and output use valid/ready handshakes so the stage can stall the datapath during a multiply.

## Interface
- `WIDTH`, default 64: operand and result width in bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `inValid`  in  1: operands and `opControl` are valid.
- `inReady`  out  1: stage can accept; transfer occurs when `inValid && inReady`.
- `opControl`  in  4: operation code (encoding below).
- `srcA`  in  WIDTH: operand A.
- `srcB`  in  WIDTH: operand B.
- `outValid`  out  1: result, zero and illegal are valid.
- `outReady`  in  1: consumer takes the result when `outValid && outReady`.
- `result`  out  WIDTH: operation result.
- `zero`  out  1: `result == 0`.
- `illegal`  out  1: the accepted `opControl` was not in the supported set.

## Operation
- Encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A−B)
  - 0111 SLT (signed A<B gives 1, else 0)
  - 1000 MUL (low WIDTH bits of unsigned A×B)
  - Any other code is illegal: result 0, zero 1, illegal 1, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- Operands and opcode are sampled only on the accept edge. Later input changes are ignored.
- FSM states: IDLE, MUL.
  - IDLE: `inReady = !outValid || outReady`.
  - IDLE, accept of a non-MUL op: register result/zero/illegal and set outValid; stay in IDLE.
  - IDLE, accept of MUL: load acc=0, mcand=srcA, mplier=srcB, cnt=0; go to MUL.
  - MUL: `inReady = 0`. Each edge: if `mplier[0]`, `acc += mcand`; `mcand <<= 1`; `mplier >>= 1`; `cnt++`.
  - MUL, on the edge where cnt reaches WIDTH−1: write the final acc to result, set outValid, go to IDLE.
- Output slot behaviour:
  - Holds its value while `outValid && !outReady`.
  - Drain with no accept in the same cycle: outValid clears.
  - Drain and non-MUL accept in the same cycle: outValid stays 1 with the new result.
  - Drain and MUL accept in the same cycle: outValid clears; the slot stays empty until the MUL completes.
- Reset (asynchronous, any state including mid-MUL): state IDLE; outValid 0; result 0; zero 0; illegal 0; acc/cnt cleared. Any in-flight MUL is abandoned with no output. `inReady` is 1 once reset deasserts.

## Timing
- Non-MUL latency: outValid is high in the cycle after the accept cycle.
- MUL latency: outValid is high WIDTH+1 cycles after the accept cycle (WIDTH iteration edges after the load edge).
- Throughput: one non-MUL op per cycle while `outReady` is held 1. MUL blocks new input for WIDTH cycles after acceptance.
- `inReady` is combinational from state, outValid and outReady. There is no combinational path from the `inValid`/data inputs to any output.
- `zero` and `illegal` update on the same edge as `result`.

## Structure
- Shared package `alu_pkg`:
  - opControl encoding as an enum (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL).
  - FSM state typedef.
  - The illegal default code 4'b1111 as a named constant.
- Sub-module `mul_iter`: shift-add iterative multiplier with start/busy/done and its own counter. The top block holds the handshake, output register and single-cycle datapath.

## Test plan
- Reset, then ADD 5+7 with `outReady` held 1 → next cycle result=12, zero=0, illegal=0; `inReady` stays 1.
- SUB 9−9 → result=0, zero=1. SLT with A=−1, B=1 → result=1. SLT with A=1, B=−1 → result=0.
- MUL 3×7 accepted at cycle 0 → `inReady`=0 for cycles 1..WIDTH; outValid=1 in cycle WIDTH+1 with result=21. Also all-ones×2 → result = all-ones<<1 (wrapped).
- Backpressure: hold `outReady`=0 after AND 0xF0&0x3C → result=0x30 is held, `inReady`=0. Then raise `outReady` with OR 0x1|0x2 presented → same-cycle drain and accept; next result=0x3, outValid never drops.
- opControl=1111 → result=0, zero=1, illegal=1 after one cycle. Next valid op clears illegal.
- Assert `rst_n`=0 midway through a MUL → outputs return to reset values immediately. After release, no stale result appears and a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes,
// FSM state encoding and the opcode legality helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000
  } op_e;

  // Code substituted for any unsupported opControl value.
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier. One partial product per clock; the low
// WIDTH bits of a*b are presented on product in the cycle done is high.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_next;

  // Next accumulator value; on the last iteration this is the product itself,
  // so the caller can capture it on the same edge without an extra cycle.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_next;

  // Load operands on start, then one shift-add step per edge while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Registered execute-stage ALU. Single-cycle logic ops, add/sub/slt, and an
// iterative multiply that stalls the input side while it runs.
//
// Handshake: an input transfer happens on a rising edge where
// inValid && inReady; an output transfer happens on a rising edge where
// outValid && outReady. Once raised, outValid and its result/zero/illegal
// stay constant until the transfer. inReady never depends on inValid or on
// the operand/opcode inputs.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       opControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             dbg_state
);

  state_e           state;
  state_e           state_nxt;
  logic             accept;
  logic             is_mul;
  logic             legal;
  logic [3:0]       op_eff;
  logic [WIDTH-1:0] alu_res;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign legal     = op_legal(opControl);
  assign op_eff    = legal ? opControl : OP_ILLEGAL;
  assign is_mul    = (opControl == OP_MUL);
  assign accept    = inValid && inReady;
  assign mul_start = accept && is_mul;
  assign dbg_state = (state == ST_MUL);

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (srcA),
    .b      (srcB),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and inReady: accept only when idle and the output slot is
  // empty or being drained this cycle.
  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    case (state)
      ST_IDLE: begin
        inReady = !mul_busy && (!outValid || outReady);
        if (inValid && inReady && is_mul) begin
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle datapath; unsupported codes produce zero.
  always_comb begin
    alu_res = '0;
    case (op_eff)
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_ADD:  alu_res = srcA + srcB;
      OP_SUB:  alu_res = srcA - srcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: alu_res = '0;
    endcase
  end

  // Output slot: multiply completion, single-cycle accept, or drain.
  // A MUL accept never loads the slot, so a concurrent drain empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else if (mul_done) begin
      outValid <= 1'b1;
      result   <= mul_product;
      zero     <= (mul_product == '0);
      illegal  <= 1'b0;
    end else if (accept && !is_mul) begin
      outValid <= 1'b1;
      result   <= alu_res;
      zero     <= (alu_res == '0);
      illegal  <= !legal;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with an expected-output queue fed from
// accepted transactions and drained on every output transfer.
module tb_alu_exec;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [3:0]   opControl = 4'b0000;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Each entry: {illegal, zero, result}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] sb_e;

  alu_exec #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .opControl(opControl),
    .srcA     (srcA),
    .srcB     (srcB),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference behaviour of one operation.
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         ill;
    ill = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
      4'b1000: r = a * b;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, (r == '0), r};
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  // Scoreboard: compare on every output transfer, then record new accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (outValid && outReady) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got result %0h, required no output", result);
        end else begin
          sb_e = exp_q.pop_front();
          if ({illegal, zero, result} !== sb_e) begin
            n_fail++;
            $display("FAIL sb_output: got ill=%0b zero=%0b res=%0h, required ill=%0b zero=%0b res=%0h",
                     illegal, zero, result, sb_e[W+1], sb_e[W], sb_e[W-1:0]);
          end
        end
      end
      if (inValid && inReady) begin
        exp_q.push_back(model(opControl, srcA, srcB));
      end
    end
  end

  // Driver: present one op until accepted; returns at posedge+1 of the cycle
  // after the accept edge. cyc is the number of cycles the op was presented.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    opControl = op;
    srcA      = a;
    srcB      = b;
    inValid   = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = inReady;
      cyc++;
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept after %0d cycles, required accept", cyc);
    end
  endtask

  // Wait for outValid (bounded); returns at the negedge where it is seen.
  task automatic wait_valid(input string name, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (outValid === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got outValid=0 for 200 cycles, required 1", name);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a completed single-cycle op in the cycle after its accept.
  task automatic expect_now(input string tag, input logic [W-1:0] r, input logic z,
                            input logic il);
    @(negedge clk);
    check_bit({tag, "_valid"}, outValid, 1'b1);
    check_val({tag, "_result"}, result, r);
    check_bit({tag, "_zero"}, zero, z);
    check_bit({tag, "_illegal"}, illegal, il);
    step();
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // Main directed sequence
  initial begin
    int           cyc;
    bit           ok;
    logic [W-1:0] ones;
    ones = '1;

    // Reset
    rst_n    = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_outvalid", outValid, 1'b0);
    check_val("rst_result", result, '0);
    check_bit("rst_zero", zero, 1'b0);
    check_bit("rst_illegal", illegal, 1'b0);
    check_bit("rst_state", dbg_state, 1'b0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("rst_inready", inReady, 1'b1);
    step();

    // ADD 5+7
    issue(4'b0010, 64'd5, 64'd7, cyc);
    check_val("add_accept_cycles", W'(cyc), W'(1));
    @(negedge clk);
    check_bit("add_valid", outValid, 1'b1);
    check_val("add_result", result, 64'd12);
    check_bit("add_zero", zero, 1'b0);
    check_bit("add_illegal", illegal, 1'b0);
    check_bit("add_inready", inReady, 1'b1);
    step();

    // SUB and SLT
    issue(4'b0110, 64'd9, 64'd9, cyc);
    expect_now("sub", '0, 1'b1, 1'b0);
    issue(4'b0111, ones, 64'd1, cyc);
    expect_now("slt_neg", 64'd1, 1'b0, 1'b0);
    issue(4'b0111, 64'd1, ones, cyc);
    expect_now("slt_pos", '0, 1'b1, 1'b0);

    // Back-to-back throughput with outReady held high
    issue(4'b0001, 64'h00ff, 64'hff00, cyc);
    check_val("tput_0", W'(cyc), W'(1));
    issue(4'b0010, 64'hffff_ffff_ffff_ffff, 64'd2, cyc);
    check_val("tput_1", W'(cyc), W'(1));
    issue(4'b0110, 64'd3, 64'd5, cyc);
    check_val("tput_2", W'(cyc), W'(1));
    expect_now("tput_sub", 64'hffff_ffff_ffff_fffe, 1'b0, 1'b0);

    // MUL 3x7, with an ADD presented (and operands changed) during the run
    issue(4'b1000, 64'd3, 64'd7, cyc);
    opControl = 4'b0010;
    srcA      = 64'd100;
    srcB      = 64'd23;
    inValid   = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (inReady !== 1'b0 || outValid !== 1'b0 || dbg_state !== 1'b1) ok = 1'b0;
      step();
    end
    check_bit("mul_busy_window", ok, 1'b1);
    @(negedge clk);
    check_bit("mul_valid", outValid, 1'b1);
    check_val("mul_result", result, 64'd21);
    check_bit("mul_zero", zero, 1'b0);
    check_bit("mul_inready_after", inReady, 1'b1);
    step();
    inValid = 1'b0;
    expect_now("post_mul_add", 64'd123, 1'b0, 1'b0);

    // MUL all-ones x 2 wraps
    issue(4'b1000, ones, 64'd2, cyc);
    wait_valid("mul2", cyc);
    check_val("mul2_latency", W'(cyc), W'(W + 1));
    check_val("mul2_result", result, ones << 1);
    step();

    // Backpressure: hold AND result, then drain and accept OR together
    outReady = 1'b0;
    issue(4'b0000, 64'hf0, 64'h3c, cyc);
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (outValid !== 1'b1 || result !== 64'h30 || inReady !== 1'b0) ok = 1'b0;
      step();
    end
    check_bit("bp_hold", ok, 1'b1);
    outReady = 1'b1;
    issue(4'b0001, 64'h1, 64'h2, cyc);
    check_val("bp_accept_cycles", W'(cyc), W'(1));
    expect_now("bp_or", 64'h3, 1'b0, 1'b0);

    // Drain and MUL accept in the same cycle empties the slot
    outReady = 1'b0;
    issue(4'b0010, 64'd1, 64'd1, cyc);
    step();
    outReady = 1'b1;
    issue(4'b1000, 64'd6, 64'd7, cyc);
    @(negedge clk);
    check_bit("drain_mul_empty", outValid, 1'b0);
    step();
    wait_valid("mul3", cyc);
    check_val("mul3_result", result, 64'd42);
    step();

    // Illegal codes, then a legal op clears illegal
    issue(4'b1111, 64'd123, 64'd456, cyc);
    expect_now("ill_f", '0, 1'b1, 1'b1);
    issue(4'b0011, 64'd5, 64'd5, cyc);
    expect_now("ill_3", '0, 1'b1, 1'b1);
    issue(4'b0010, 64'd1, 64'd2, cyc);
    expect_now("ill_clear", 64'd3, 1'b0, 1'b0);

    // Reset in the middle of a MUL
    issue(4'b1000, 64'd5, 64'd5, cyc);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check_bit("midrst_outvalid", outValid, 1'b0);
    check_val("midrst_result", result, '0);
    check_bit("midrst_zero", zero, 1'b0);
    check_bit("midrst_illegal", illegal, 1'b0);
    check_bit("midrst_state", dbg_state, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("midrst_inready", inReady, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < W + 5; k++) begin
      step();
      @(negedge clk);
      if (outValid !== 1'b0) ok = 1'b0;
    end
    check_bit("midrst_no_stale", ok, 1'b1);
    step();
    issue(4'b0010, 64'd2, 64'd3, cyc);
    expect_now("midrst_add", 64'd5, 1'b0, 1'b0);

    repeat (3) step();
    check_val("sb_queue_empty", W'(exp_q.size()), '0);
    summary();
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    summary();
    $finish;
  end

endmodule
